// File: rtl/jtoutrun_rdbuf.sv
// Double-buffered road line buffer: captures one scanline, replays it on the next one shifted by hofs.
// Optional macro JTOUTRUN_RDBUF_GFXEN_EN adds a gfx_en input that blanks the output layer.
module jtoutrun_rdbuf #(
    parameter int HW = 9,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          hs,
    input  logic [7:0]    road_pxl,
    input  logic [1:0]    road_rc,
    input  logic [HW-1:0] hofs,
`ifdef JTOUTRUN_RDBUF_GFXEN_EN
    input  logic          gfx_en,
`endif
    output logic [7:0]    pxl,
    output logic [1:0]    rc,
    output logic          line_ok
);

    localparam logic [HW-1:0] HMAX = '1;

    logic          hs_l_q,    hs_l_d;
    logic          wr_bank_q, wr_bank_d;
    logic [HW-1:0] wr_h_q,    wr_h_d;
    logic          full_q,    full_d;
    logic          wrote_q,   wrote_d;
    logic [1:0]    vld_q,     vld_d;
    logic [HW-1:0] rd_h_q,    rd_h_d;
    logic [DW-1:0] out_q,     out_d;
    logic          line_ok_q, line_ok_d;

    logic          hs_rise, hs_fall, we, gfx_on;
    logic [HW-1:0] wr_addr;
    logic [DW-1:0] wdata, ram_q;

    // Both banks live in one array; the bank bit is the address MSB.
    logic [DW-1:0] mem [0:2**(HW+1)-1];

`ifdef JTOUTRUN_RDBUF_GFXEN_EN
    assign gfx_on = gfx_en;
`else
    assign gfx_on = 1'b1;
`endif

    assign hs_rise = hs & ~hs_l_q;
    assign hs_fall = ~hs & hs_l_q;
    assign wr_addr = hs_fall ? '0 : wr_h_q;
    // A write in the hs_fall cycle starts a fresh line, so the stale full flag must not block it.
    assign we      = pxl_cen & ~hs & (hs_fall | ~full_q);
    assign wdata   = DW'({road_rc, road_pxl});

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank_q, wr_addr}] <= wdata;
        end
        ram_q <= mem[{~wr_bank_q, rd_h_q}];
    end

    always_comb begin
        hs_l_d    = hs;
        wr_bank_d = wr_bank_q;
        wr_h_d    = wr_h_q;
        full_d    = full_q;
        wrote_d   = wrote_q;
        vld_d     = vld_q;
        rd_h_d    = rd_h_q;
        out_d     = out_q;
        line_ok_d = vld_q[~wr_bank_q];

        if (hs_fall) begin
            wr_h_d           = '0;
            full_d           = 1'b0;
            wrote_d          = 1'b0;
            vld_d[wr_bank_q] = 1'b0;
            rd_h_d           = hofs;
        end else if (pxl_cen && !hs) begin
            rd_h_d = rd_h_q + 1'b1;
        end

        if (we) begin
            wrote_d = 1'b1;
            if (wr_addr == HMAX) begin
                full_d = 1'b1;
                wr_h_d = wr_addr;
            end else begin
                wr_h_d = wr_addr + 1'b1;
            end
        end

        if (hs_rise) begin
            vld_d[wr_bank_q] = wrote_q;
            wr_bank_d        = ~wr_bank_q;
        end

        if (pxl_cen) begin
            out_d = (!hs && vld_q[~wr_bank_q] && gfx_on) ? ram_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_l_q    <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_h_q    <= '0;
            full_q    <= 1'b0;
            wrote_q   <= 1'b0;
            vld_q     <= 2'b00;
            rd_h_q    <= '0;
            out_q     <= '0;
            line_ok_q <= 1'b0;
        end else begin
            hs_l_q    <= hs_l_d;
            wr_bank_q <= wr_bank_d;
            wr_h_q    <= wr_h_d;
            full_q    <= full_d;
            wrote_q   <= wrote_d;
            vld_q     <= vld_d;
            rd_h_q    <= rd_h_d;
            out_q     <= out_d;
            line_ok_q <= line_ok_d;
        end
    end

    assign pxl     = out_q[7:0];
    assign rc      = out_q[9:8];
    assign line_ok = line_ok_q;

endmodule
